// File: rtl/mc_mem_responder.sv
// ============================================================================
// Module   : mc_mem_responder
// Purpose  : Word-addressed RAM that answers MemRead/MemWrite strobes after
//            LATENCY cycles, with a one-cycle ready pulse and a busy flag.
//            Optional macro MEM_ALIGN_CHECK_EN enables misaligned-access error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_mem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    op_wr_q, op_wr_d;
    logic                    mis_q, mis_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    mem_we;

    logic [DATA_W-1:0]       mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   addr_idx;
    logic                    addr_mis;
    logic                    unused_addr_bits;

    assign addr_idx         = addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{addr[ADDR_W-1:DEPTH_LOG2+2], addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign addr_mis = |addr[1:0];
`else
    assign addr_mis = 1'b0;
`endif

    // Read data is loaded on the edge entering RESP so it appears with ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        mis_d   = mis_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_read | mem_write) begin
                    op_wr_d = mem_write;
                    mis_d   = addr_mis;
                    idx_d   = addr_idx;
                    wdata_d = wdata;
                    cnt_d   = LAT_M1;
                    if (LATENCY > 1) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESP;
                        if (!mem_write) begin
                            rdata_d = addr_mis ? '0 : mem[addr_idx];
                        end
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    if (!op_wr_q) begin
                        rdata_d = mis_q ? '0 : mem[idx_q];
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                mem_we  = op_wr_q & ~mis_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            mis_q   <= mis_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ready = (state_q == S_RESP);
    assign busy  = (state_q != S_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
    assign err = (state_q == S_RESP) & mis_q;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire
